mem_interface: RTL and testbench

- Data-memory interface between the TRV32I core's load/store path and the data memory.
- Accepts one load/store request from the core, checks alignment and funct3 legality, and generates word-aligned address, lane-replicated store data and byte enables.
- Runs a ready-handshake with a variable-latency memory and returns sign- or zero-extended load data.
- Stalls the core for the whole access, with a timeout so a stuck memory cannot hang the pipeline.

---
 rtl/trv32i_mem_pkg.sv | 17 +
 rtl/mem_lane_align.sv | 28 ++
 rtl/mem_interface.sv | 102 ++++++++++
 tb/tb_mem_interface.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/trv32i_mem_pkg.sv
// trv32i_mem_pkg: funct3 codes, FSM state type and request legality check shared by the data-memory interface
package trv32i_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_state_t;
  // Legal funct3 for the direction, and naturally aligned for its size.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3, input logic [1:0] addr);
    return funct3 == F3_B  ? 1'b1 :
           funct3 == F3_BU ? !we :
           funct3 == F3_H  ? !addr[0] :
           funct3 == F3_HU ? (!we && !addr[0]) :
           funct3 == F3_W  ? (addr == 2'b00) : 1'b0;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store data replication, byte-enable generation and load extract/extend
//   funct3/lane : access size code and byte lane (addr[1:0])
//   wdata       : right-justified store data  -> wdata_rep, byte_en
//   rdata       : memory read word            -> load_data (extended)
module mem_lane_align
  import trv32i_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] wdata_rep,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{lane, 3'b000} +: 8];
    h = rdata[{lane[1], 4'b0000} +: 16];
    wdata_rep = funct3 == F3_B ? {4{wdata[7:0]}} : funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    byte_en = funct3 == F3_B ? 4'b0001 << lane : funct3 == F3_H ? 4'b0011 << lane : 4'b1111;
    load_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'b0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/mem_interface.sv
// mem_interface: TRV32I load/store path to a variable-latency data memory with timeout
//   core_*  : request (req/we/funct3/addr/wdata) and response (rdata/stall/done/err)
//   mem_*   : word-aligned address, replicated write data, held strobes, byte enables, ready/rdata
//   rst     : asynchronous, active-low
module mem_interface
  import trv32i_mem_pkg::*;
#(
  parameter int B_WIDTH = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 core_req,
  input  logic                 core_we,
  input  logic [2:0]           core_funct3,
  input  logic [B_WIDTH-1:0]   core_addr,
  input  logic [B_WIDTH-1:0]   core_wdata,
  output logic [B_WIDTH-1:0]   core_rdata,
  output logic                 core_stall,
  output logic                 core_done,
  output logic                 core_err,
  output logic [B_WIDTH-1:0]   mem_addr,
  output logic [B_WIDTH-1:0]   mem_wdata,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic [B_WIDTH/8-1:0] write_byte_en,
  input  logic                 mem_ready,
  input  logic [B_WIDTH-1:0]   mem_rdata
);
  if (B_WIDTH != 32 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_interface: B_WIDTH must be 32 and TIMEOUT at least 1");
  end
  localparam int CW = $clog2(TIMEOUT + 1);
  mem_state_t      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_r;
  logic [1:0]      lane_r;
  logic            we_r, err_r;
  logic [31:0]     wdata_rep, load_data;
  logic [3:0]      byte_en;
  // One aligner serves both paths: core fields while idle (store setup), latched fields during the access (load extract).
  mem_lane_align u_align (
    .funct3    (state == IDLE ? core_funct3 : f3_r),
    .lane      (state == IDLE ? core_addr[1:0] : lane_r),
    .wdata     (core_wdata),
    .rdata     (mem_rdata),
    .wdata_rep (wdata_rep),
    .byte_en   (byte_en),
    .load_data (load_data)
  );
  // Stall is gated by rst so every output reads 0 during reset even with core_req held.
  assign core_stall   = rst && ((state == IDLE && core_req) || state == ACCESS);
  assign core_done    = state == RESP;
  assign core_err     = state == RESP && err_r;
  assign mem_read_en  = state == ACCESS && !we_r;
  assign mem_write_en = state == ACCESS && we_r;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      f3_r          <= '0;
      lane_r        <= '0;
      we_r          <= 1'b0;
      err_r         <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      write_byte_en <= '0;
      core_rdata    <= '0;
    end else begin
      case (state)
        IDLE: if (core_req) begin
          if (is_legal(core_we, core_funct3, core_addr[1:0])) begin
            state         <= ACCESS;
            cnt           <= '0;
            f3_r          <= core_funct3;
            lane_r        <= core_addr[1:0];
            we_r          <= core_we;
            err_r         <= 1'b0;
            mem_addr      <= {core_addr[B_WIDTH-1:2], 2'b00};
            mem_wdata     <= core_we ? wdata_rep : '0;
            write_byte_en <= core_we ? byte_en : '0;
          end else begin
            state      <= RESP;
            err_r      <= 1'b1;
            core_rdata <= '0;
          end
        end
        ACCESS: if (mem_ready) begin
          state      <= RESP;
          core_rdata <= we_r ? core_rdata : load_data;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          state      <= RESP;
          err_r      <= 1'b1;
          core_rdata <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_interface.sv
// tb_mem_interface: directed self-checking bench for mem_interface (TIMEOUT=8)
module tb_mem_interface;
  logic        clk = 0, rst = 0, core_req = 0, core_we = 0, mem_ready = 0;
  logic [2:0]  core_funct3 = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, mem_rdata = 0;
  logic [31:0] core_rdata, mem_addr, mem_wdata;
  logic        core_stall, core_done, core_err, mem_read_en, mem_write_en;
  logic [3:0]  write_byte_en;
  int          n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  mem_interface #(.B_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .core_done(core_done), .core_err(core_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .write_byte_en(write_byte_en),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    core_req = 1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = w;
    #1;
  endtask
  task automatic quick_load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    nxt(); req(0, f3, a, 0);
    nxt(); #1;
    chk({tag, "_rd"}, mem_read_en, 1);
    chk({tag, "_be"}, write_byte_en, 0);
    nxt(); core_req = 0; #1;
    chk({tag, "_done"}, core_done, 1);
    chk({tag, "_err"}, core_err, 0);
    chk({tag, "_rdata"}, core_rdata, exp);
  endtask
  task automatic bad(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
    nxt(); req(we, f3, a, 32'h1234_5678);
    chk({tag, "_rd_c0"}, mem_read_en, 0);
    chk({tag, "_wr_c0"}, mem_write_en, 0);
    nxt(); core_req = 0; #1;
    chk({tag, "_done"}, core_done, 1);
    chk({tag, "_err"}, core_err, 1);
    chk({tag, "_rdata"}, core_rdata, 0);
    chk({tag, "_strobe"}, {mem_read_en, mem_write_en}, 0);
    nxt(); #1;
    chk({tag, "_done_after"}, core_done, 0);
    chk({tag, "_err_after"}, core_err, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    #12 core_req = 1; #1;
    chk("rst_stall", core_stall, 0);
    chk("rst_done", core_done, 0);
    chk("rst_err", core_err, 0);
    chk("rst_strobes", {mem_read_en, mem_write_en}, 0);
    chk("rst_be", write_byte_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", core_rdata, 0);
    core_req = 0;
    @(negedge clk) rst = 1;
    // SW, zero-wait memory
    nxt(); mem_ready = 1; req(1, 3'b010, 32'h104, 32'hDEAD_BEEF);
    chk("sw_stall_c0", core_stall, 1);
    chk("sw_wr_c0", mem_write_en, 0);
    nxt(); #1;
    chk("sw_wr", mem_write_en, 1);
    chk("sw_rd", mem_read_en, 0);
    chk("sw_be", write_byte_en, 4'hF);
    chk("sw_addr", mem_addr, 32'h104);
    chk("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("sw_stall_c1", core_stall, 1);
    chk("sw_done_c1", core_done, 0);
    nxt(); core_req = 0; #1;
    chk("sw_done", core_done, 1);
    chk("sw_err", core_err, 0);
    chk("sw_wr_c2", mem_write_en, 0);
    chk("sw_stall_c2", core_stall, 0);
    nxt(); #1;
    chk("sw_done_c3", core_done, 0);
    // SB to lane 3
    nxt(); req(1, 3'b000, 32'h203, 32'h0000_00A5);
    nxt(); #1;
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_be", write_byte_en, 4'b1000);
    chk("sb_addr", mem_addr, 32'h200);
    chk("sb_wr", mem_write_en, 1);
    nxt(); core_req = 0; #1;
    chk("sb_done", core_done, 1);
    chk("sb_err", core_err, 0);
    // Loads from word 0x1280FF00
    mem_rdata = 32'h1280_FF00;
    quick_load("lb",   3'b000, 32'h302, 32'hFFFF_FF80);
    quick_load("lbu",  3'b100, 32'h302, 32'h0000_0080);
    quick_load("lh",   3'b001, 32'h302, 32'h0000_1280);
    quick_load("lh0",  3'b001, 32'h300, 32'hFFFF_FF00);
    quick_load("lhu0", 3'b101, 32'h300, 32'h0000_FF00);
    quick_load("lb1",  3'b000, 32'h301, 32'hFFFF_FFFF);
    quick_load("lw",   3'b010, 32'h300, 32'h1280_FF00);
    // Error responses
    bad("lw_mis", 0, 3'b010, 32'h401);
    bad("ld_f3",  0, 3'b011, 32'h400);
    bad("sh_mis", 1, 3'b001, 32'h101);
    bad("st_f3",  1, 3'b100, 32'h100);
    bad("lh_mis", 0, 3'b001, 32'h303);
    // LW with three wait cycles
    nxt(); mem_ready = 0; mem_rdata = 32'hCAFE_F00D; req(0, 3'b010, 32'h500, 0);
    for (int i = 1; i <= 4; i++) begin
      nxt(); if (i == 4) mem_ready = 1; #1;
      chk("ws_rd", mem_read_en, 1);
      chk("ws_addr", mem_addr, 32'h500);
      chk("ws_stall", core_stall, 1);
      chk("ws_done", core_done, 0);
    end
    nxt(); core_req = 0; mem_ready = 0; #1;
    chk("ws_done_end", core_done, 1);
    chk("ws_err", core_err, 0);
    chk("ws_rdata", core_rdata, 32'hCAFE_F00D);
    chk("ws_rd_end", mem_read_en, 0);
    // Reset in the middle of an access
    nxt(); req(0, 3'b010, 32'h700, 0);
    nxt(); #1;
    chk("rs_rd_before", mem_read_en, 1);
    #1 rst = 0; #1;
    chk("rs_rd", mem_read_en, 0);
    chk("rs_stall", core_stall, 0);
    chk("rs_addr", mem_addr, 0);
    chk("rs_rdata", core_rdata, 0);
    chk("rs_done", core_done, 0);
    @(negedge clk) rst = 1; core_req = 0;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("rs_no_done", core_done, 0);
    end
    mem_ready = 1; mem_rdata = 32'h1280_FF00;
    quick_load("post_rst", 3'b100, 32'h301, 32'h0000_00FF);
    // Timeout: memory never ready
    nxt(); mem_ready = 0; req(0, 3'b010, 32'h600, 0);
    for (int i = 1; i <= 8; i++) begin
      nxt(); #1;
      chk("to_rd", mem_read_en, 1);
      chk("to_done", core_done, 0);
    end
    nxt(); core_req = 0; #1;
    chk("to_done_end", core_done, 1);
    chk("to_err", core_err, 1);
    chk("to_rdata", core_rdata, 0);
    chk("to_rd_end", mem_read_en, 0);
    nxt(); #1;
    chk("to_done_after", core_done, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
